// File: rtl/request_unit_if.sv
// request_unit_if: bundles the control-unit request inputs, the I/D cache
// handshake, the coherence snoop and the status outputs of request_unit.
// The master side (control unit / caches / bench) drives the requests and
// hits; the slave side (request_unit) drives the cache enables and status.
interface request_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);

  // control unit decode
  logic              halt;
  logic              dread;
  logic              dwrite;
  logic              datomic;
  logic [ADDR_W-1:0] daddr;

  // cache responses
  logic              ihit;
  logic              dhit;

  // coherence snoop
  logic              ccinv;
  logic [ADDR_W-1:0] ccsnoopaddr;

  // cache requests and status
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic              pc_en;
  logic              halt_o;
  logic              sc_result;
  logic              link_valid;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output halt, dread, dwrite, datomic, daddr,
    output ihit, dhit, ccinv, ccsnoopaddr,
    input  iREN, dREN, dWEN, pc_en, halt_o, sc_result, link_valid, stall_cnt
  );

  modport slave (
    input  halt, dread, dwrite, datomic, daddr,
    input  ihit, dhit, ccinv, ccsnoopaddr,
    output iREN, dREN, dWEN, pc_en, halt_o, sc_result, link_valid, stall_cnt
  );

endinterface

// File: rtl/request_unit.sv
// request_unit: turns decoded memory requests into I/D cache handshakes for a
// single-cycle datapath. One instruction is fetched, optionally followed by a
// data access, and then retired with a one-cycle pc_en strobe. Also owns the
// LL/SC link register (with snoop invalidation) and the sticky halt.
module request_unit #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  request_unit_if.slave io_bus
);

  // FSM encoding
  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_MEM    = 2'd1;
  localparam logic [1:0] S_SCFAIL = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  // state and latched request
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_dread;
  logic              r_dwrite;
  logic              r_datomic;
  logic [ADDR_W-1:0] r_daddr;

  // link register
  logic              r_link_valid;
  logic [ADDR_W-1:0] r_link_addr;
  logic              w_link_valid_next;
  logic [ADDR_W-1:0] w_link_addr_next;

  // registered status outputs
  logic              r_pc_en;
  logic              w_pc_en_next;
  logic              r_sc_result;
  logic [CNT_W-1:0]  r_stall_cnt;

  // decode helpers
  logic w_fetch_go;
  logic w_mem_op;
  logic w_is_sc;
  logic w_link_match;
  logic w_take_req;
  logic w_mem_done;
  logic w_ll_done;
  logic w_sc_done;
  logic w_sw_done;
  logic w_snoop_hit;

  // An instruction is accepted in FETCH only when the icache delivers it.
  assign w_fetch_go   = (r_state == S_FETCH) && io_bus.ihit;
  assign w_mem_op     = io_bus.dread || io_bus.dwrite;
  // A store with datomic is an SC; a load wins if both strobes ever appear.
  assign w_is_sc      = io_bus.dwrite && io_bus.datomic && !io_bus.dread;
  assign w_link_match = r_link_valid && (r_link_addr == io_bus.daddr);
  assign w_take_req   = w_fetch_go && !io_bus.halt && w_mem_op;

  // Completions are qualified by the latched request, not the live inputs,
  // so the control unit may move on once the instruction has been accepted.
  assign w_mem_done = (r_state == S_MEM) && io_bus.dhit;
  assign w_ll_done  = w_mem_done && r_dread  && r_datomic;
  assign w_sc_done  = w_mem_done && r_dwrite && r_datomic;
  assign w_sw_done  = w_mem_done && r_dwrite && !r_datomic;

  // Next-state logic; halt takes priority over any data request.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (io_bus.ihit) begin
          if (io_bus.halt) begin
            w_state_next = S_HALT;
          end else if (w_mem_op) begin
            if (w_is_sc && !w_link_match) begin
              w_state_next = S_SCFAIL;
            end else begin
              w_state_next = S_MEM;
            end
          end
        end
      end
      S_MEM: begin
        if (io_bus.dhit) begin
          w_state_next = S_FETCH;
        end
      end
      S_SCFAIL: begin
        w_state_next = S_FETCH;
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Retire strobe: a non-memory instruction, a finished data access or a
  // failed SC each produce exactly one pc_en cycle after the deciding cycle.
  assign w_pc_en_next = (w_fetch_go && !io_bus.halt && !w_mem_op)
                     || w_mem_done
                     || (r_state == S_SCFAIL);

  // Link register update. The snoop is compared against the address the link
  // will hold after this cycle, so an LL to a different address survives a
  // snoop of the old one, while a snoop of the LL's own address kills it.
  always_comb begin
    w_link_valid_next = r_link_valid;
    w_link_addr_next  = r_link_addr;
    if (w_ll_done) begin
      w_link_valid_next = 1'b1;
      w_link_addr_next  = r_daddr;
    end else if (w_sc_done || (r_state == S_SCFAIL)) begin
      w_link_valid_next = 1'b0;
    end else if (w_sw_done && (r_daddr == r_link_addr)) begin
      w_link_valid_next = 1'b0;
    end
    if (w_snoop_hit) begin
      w_link_valid_next = 1'b0;
    end
  end

  assign w_snoop_hit = io_bus.ccinv && (io_bus.ccsnoopaddr == w_link_addr_next);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the data request when the instruction is accepted; it stays
  // stable for the whole MEM phase regardless of the control unit inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dread   <= 1'b0;
      r_dwrite  <= 1'b0;
      r_datomic <= 1'b0;
      r_daddr   <= '0;
    end else if (w_take_req) begin
      r_dread   <= io_bus.dread;
      r_dwrite  <= io_bus.dwrite && !io_bus.dread;
      r_datomic <= io_bus.datomic;
      r_daddr   <= io_bus.daddr;
    end
  end

  // Link register state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
    end else begin
      r_link_valid <= w_link_valid_next;
      r_link_addr  <= w_link_addr_next;
    end
  end

  // Retire strobe and SC outcome; sc_result only changes when an SC retires.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc_en     <= 1'b0;
      r_sc_result <= 1'b0;
    end else begin
      r_pc_en <= w_pc_en_next;
      if (w_sc_done) begin
        r_sc_result <= 1'b1;
      end else if (r_state == S_SCFAIL) begin
        r_sc_result <= 1'b0;
      end
    end
  end

  // Saturating count of cycles spent waiting on the dcache.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_MEM) && !io_bus.dhit && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Moore cache enables. iREN is masked by RST so it stays low while reset
  // is held and rises as soon as reset is released.
  assign io_bus.iREN       = (r_state == S_FETCH) && !RST;
  assign io_bus.dREN       = (r_state == S_MEM) && r_dread;
  assign io_bus.dWEN       = (r_state == S_MEM) && r_dwrite;
  assign io_bus.halt_o     = (r_state == S_HALT);
  assign io_bus.pc_en      = r_pc_en;
  assign io_bus.sc_result  = r_sc_result;
  assign io_bus.link_valid = r_link_valid;
  assign io_bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed vectors for request_unit with hand-computed
// expectations. Inputs change 1 ns after the rising edge, outputs are sampled
// at the same point. A narrow stall counter keeps the saturation case short.
module tb_request_unit;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   dren_cnt;

  request_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  request_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK    (clk),
    .RST    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with ihit for a single cycle, then clear the decode.
  task automatic issue(input logic h, input logic dr, input logic dw, input logic at,
                       input logic [31:0] a);
    bus.ihit    = 1'b1;
    bus.halt    = h;
    bus.dread   = dr;
    bus.dwrite  = dw;
    bus.datomic = at;
    bus.daddr   = a;
    tick();
    bus.ihit    = 1'b0;
    bus.halt    = 1'b0;
    bus.dread   = 1'b0;
    bus.dwrite  = 1'b0;
    bus.datomic = 1'b0;
  endtask

  // Hold dhit low for some MEM cycles, then complete with one dhit cycle.
  task automatic finish_mem(input int waits);
    for (int c = 0; c < waits; c++) tick();
    bus.dhit = 1'b1;
    tick();
    bus.dhit = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.halt = 1'b0; bus.dread = 1'b0; bus.dwrite = 1'b0; bus.datomic = 1'b0;
    bus.daddr = '0; bus.ihit = 1'b0; bus.dhit = 1'b0;
    bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;

    // Reset state
    #2;
    chk("rst_iren", 32'(bus.iREN), 0);
    chk("rst_dren", 32'(bus.dREN), 0);
    chk("rst_dwen", 32'(bus.dWEN), 0);
    chk("rst_pc_en", 32'(bus.pc_en), 0);
    chk("rst_halt_o", 32'(bus.halt_o), 0);
    chk("rst_link", 32'(bus.link_valid), 0);
    chk("rst_stall", 32'(bus.stall_cnt), 0);
    chk("rst_sc", 32'(bus.sc_result), 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rel_iren", 32'(bus.iREN), 1);

    // 1. plain instruction: pc_en one cycle after the ihit cycle, one cycle wide
    bus.ihit = 1'b1;
    #1;
    chk("t1_pc_en_during_ihit", 32'(bus.pc_en), 0);
    tick();
    bus.ihit = 1'b0;
    chk("t1_pc_en", 32'(bus.pc_en), 1);
    chk("t1_iren", 32'(bus.iREN), 1);
    tick();
    chk("t1_pc_en_drop", 32'(bus.pc_en), 0);

    // 2. LW 0x100 with dhit on the third MEM cycle
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
    chk("t2_iren_mem", 32'(bus.iREN), 0);
    dren_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.dREN) dren_cnt++;
      chk("t2_pc_en_wait", 32'(bus.pc_en), 0);
      if (c == 2) begin
        chk("t2_stall", 32'(bus.stall_cnt), 2);
        bus.dhit = 1'b1;
      end
      tick();
    end
    bus.dhit = 1'b0;
    chk("t2_dren_cycles", 32'(dren_cnt), 3);
    chk("t2_pc_en", 32'(bus.pc_en), 1);
    chk("t2_dren_off", 32'(bus.dREN), 0);
    tick();
    chk("t2_pc_en_once", 32'(bus.pc_en), 0);
    chk("t2_stall_hold", 32'(bus.stall_cnt), 2);

    // 3. LL 0x200 then SC 0x200, immediate dhit
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("t3_ll_dren", 32'(bus.dREN), 1);
    finish_mem(0);
    chk("t3_ll_link", 32'(bus.link_valid), 1);
    issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    chk("t3_sc_dwen", 32'(bus.dWEN), 1);
    chk("t3_sc_dren", 32'(bus.dREN), 0);
    finish_mem(0);
    chk("t3_sc_pc_en", 32'(bus.pc_en), 1);
    chk("t3_sc_result", 32'(bus.sc_result), 1);
    chk("t3_sc_link", 32'(bus.link_valid), 0);
    chk("t3_sc_dwen_off", 32'(bus.dWEN), 0);

    // 4. LL 0x200, unrelated snoop keeps link, matching snoop kills it, SC fails
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    finish_mem(0);
    bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h300;
    tick();
    chk("t4_snoop_other", 32'(bus.link_valid), 1);
    bus.ccsnoopaddr = 32'h200;
    tick();
    bus.ccinv = 1'b0;
    chk("t4_snoop_hit", 32'(bus.link_valid), 0);
    issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    chk("t4_scfail_dwen", 32'(bus.dWEN), 0);
    chk("t4_scfail_iren", 32'(bus.iREN), 0);
    chk("t4_scfail_pc_wait", 32'(bus.pc_en), 0);
    tick();
    chk("t4_scfail_pc_en", 32'(bus.pc_en), 1);
    chk("t4_scfail_result", 32'(bus.sc_result), 0);
    chk("t4_scfail_dwen2", 32'(bus.dWEN), 0);
    tick();
    chk("t4_scfail_pc_once", 32'(bus.pc_en), 0);

    // Same-cycle LL completion and snoop: different address keeps the link
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
    bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h600;
    finish_mem(0);
    bus.ccinv = 1'b0;
    chk("ll_snoop_diff", 32'(bus.link_valid), 1);
    // Store to another word leaves the link, store to the linked word clears it
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h504);
    finish_mem(1);
    chk("sw_other_link", 32'(bus.link_valid), 1);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h500);
    finish_mem(0);
    chk("sw_same_link", 32'(bus.link_valid), 0);
    chk("sw_stall", 32'(bus.stall_cnt), 3);
    // Same-cycle LL completion and snoop to the same address: invalidate wins
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
    bus.ccinv = 1'b1; bus.ccsnoopaddr = 32'h400;
    finish_mem(0);
    bus.ccinv = 1'b0;
    chk("ll_snoop_same", 32'(bus.link_valid), 0);

    // Stall counter saturates at all-ones (3 + 20 clamps to 15)
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h700);
    for (int c = 0; c < 20; c++) tick();
    chk("stall_sat", 32'(bus.stall_cnt), 15);
    chk("stall_sat_dren", 32'(bus.dREN), 1);
    finish_mem(0);
    chk("stall_sat_pc_en", 32'(bus.pc_en), 1);
    chk("stall_sat_hold", 32'(bus.stall_cnt), 15);

    // 5. halt together with dread: HALT wins, sticky across ihit toggles
    issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h800);
    chk("t5_halt_o", 32'(bus.halt_o), 1);
    chk("t5_dren", 32'(bus.dREN), 0);
    chk("t5_iren", 32'(bus.iREN), 0);
    chk("t5_pc_en", 32'(bus.pc_en), 0);
    for (int c = 0; c < 3; c++) begin
      bus.ihit  = (c % 2 == 0);
      bus.dread = 1'b1;
      tick();
      chk("t5_halt_sticky", 32'(bus.halt_o), 1);
      chk("t5_no_pc_en", 32'(bus.pc_en), 0);
      chk("t5_no_dren", 32'(bus.dREN), 0);
    end
    bus.ihit = 1'b0; bus.dread = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_halt_o", 32'(bus.halt_o), 0);
    tick();
    rst = 1'b0;

    // 6. reset in the middle of a store with a live link
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h900);
    finish_mem(0);
    chk("t6_link_set", 32'(bus.link_valid), 1);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'hA00);
    chk("t6_dwen", 32'(bus.dWEN), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_dwen_rst", 32'(bus.dWEN), 0);
    chk("t6_link_rst", 32'(bus.link_valid), 0);
    chk("t6_iren_in_rst", 32'(bus.iREN), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_iren_rel", 32'(bus.iREN), 1);
    tick();
    chk("t6_dwen_after", 32'(bus.dWEN), 0);
    chk("t6_pc_en_after", 32'(bus.pc_en), 0);
    chk("t6_stall_after", 32'(bus.stall_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
